int_reg_scoreboard: RTL and testbench

//  Tracks integer-register writes still in flight from long-latency producers: divider, FP->int ops, and MMIO/uncached loads.

---
 rtl/int_reg_scoreboard.sv | 139 +++++++++++++
 tb/tb_int_reg_scoreboard.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : int_reg_scoreboard                                             |
// | Purpose : Busy-bit scoreboard for integer registers written by           |
// |           long-latency producers (divider, FP->int, uncached loads).     |
// |           ID marks rd busy at issue, WB clears it at completion, and     |
// |           consumers (RAW) or overwriters (WAW) of a busy reg stall.      |
// | Option  : `define SCOREBOARD_TIMEOUT_EN adds a per-register age          |
// |           watchdog driving the sticky o_timeout flag.                    |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module int_reg_scoreboard #(
   parameter int XLEN        = 32,
   parameter int NUM_REGS    = 32,
   parameter int MAX_PENDING = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_issue_valid,
   input  logic [4:0]  i_issue_rd,
   output logic        o_issue_ready,
   input  logic        i_cmpl_valid,
   input  logic [4:0]  i_cmpl_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [4:0]  i_rd,
   input  logic        i_rd_writes,
   output logic        o_stall,
   output logic [2:0]  o_pending_cnt,
   output logic [31:0] o_busy_vec,
   output logic        o_spurious,
   output logic        o_timeout
);

   localparam logic [2:0] MAX_P = 3'(MAX_PENDING);

   // XLEN only documents the datapath this block sits beside
   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("int_reg_scoreboard: unsupported XLEN");
   end

   logic [NUM_REGS-1:1] busy;
   logic [2:0]          count;
   logic [31:0]         busy_vec;
   logic [31:0]         eff_busy;
   logic [31:0]         set_mask;
   logic [31:0]         clr_mask;
   logic [31:0]         busy_next;
   logic                cmpl_hit;
   logic                issue_acc;
   logic                issue_ready;
   logic                spurious;

   // Expand tracked flops to a full 32-bit vector; x0 is never busy
   always_comb begin
      busy_vec                = '0;
      busy_vec[NUM_REGS-1:1] = busy;
   end

   // Completion bypass, issue acceptance and next-state busy vector
   always_comb begin
      cmpl_hit    = i_cmpl_valid && (i_cmpl_rd != 5'd0) && busy_vec[i_cmpl_rd];
      clr_mask    = i_cmpl_valid ? (32'd1 << i_cmpl_rd) : 32'd0;
      eff_busy    = busy_vec & ~clr_mask;
      // a completing write frees its slot in time for a new issue
      issue_ready = (count < MAX_P) || cmpl_hit;
      issue_acc   = i_issue_valid && issue_ready && (i_issue_rd != 5'd0);
      set_mask    = issue_acc ? (32'd1 << i_issue_rd) : 32'd0;
      // set after clear: same-rd issue+completion leaves the new write tracked
      busy_next   = (busy_vec & ~(cmpl_hit ? clr_mask : 32'd0)) | set_mask;
   end

   assign o_stall       = eff_busy[i_rs1] | eff_busy[i_rs2] | (i_rd_writes & eff_busy[i_rd]);
   assign o_issue_ready = issue_ready;
   assign o_pending_cnt = count;
   assign o_busy_vec    = busy_vec;
   assign o_spurious    = spurious;

   // Busy bits, pending count and spurious-completion pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy     <= '0;
         count    <= 3'd0;
         spurious <= 1'b0;
      end else if (i_flush) begin
         busy     <= '0;
         count    <= 3'd0;
         spurious <= 1'b0;
      end else begin
         busy     <= busy_next[NUM_REGS-1:1];
         spurious <= i_cmpl_valid && !cmpl_hit;
         if (issue_acc && !cmpl_hit) begin
            if (count != MAX_P) count <= count + 3'd1;
         end else if (cmpl_hit && !issue_acc) begin
            if (count != 3'd0) count <= count - 3'd1;
         end
      end
   end

`ifdef SCOREBOARD_TIMEOUT_EN
   localparam logic [7:0] LIM = 8'(TIMEOUT_CYC);

   logic [7:0] age [NUM_REGS-1:1];
   logic       timeout_flag;
   logic       any_reach;

   // Some busy register is about to complete its TIMEOUT_CYC-th busy cycle
   always_comb begin
      any_reach = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (busy[r] && (age[r] >= LIM - 8'd1)) any_reach = 1'b1;
      end
   end

   // Per-register age counters and the sticky watchdog flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 1; r < NUM_REGS; r++) age[r] <= 8'd0;
         timeout_flag <= 1'b0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (i_flush || set_mask[r])
               age[r] <= 8'd0;
            else if (busy[r] && (age[r] != LIM))
               age[r] <= age[r] + 8'd1;
         end
         if (any_reach) timeout_flag <= 1'b1;
      end
   end

   assign o_timeout = timeout_flag;
`else
   assign o_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_int_reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_int_reg_scoreboard                                          |
// | Purpose : Scoreboard bench for int_reg_scoreboard. The driver pushes     |
// |           hand-computed expectations tagged with a cycle number; a       |
// |           monitor pops and compares them on the falling edge.            |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_int_reg_scoreboard;

   localparam int TCYC = 16;

   localparam int K_STALL = 0;
   localparam int K_READY = 1;
   localparam int K_CNT   = 2;
   localparam int K_BUSY  = 3;
   localparam int K_SPUR  = 4;
   localparam int K_TOUT  = 5;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        cmpl_valid;
   logic [4:0]  cmpl_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        rd_writes;
   logic        stall;
   logic [2:0]  pending_cnt;
   logic [31:0] busy_vec;
   logic        spurious;
   logic        timeout;

   int   cyc      = 0;
   int   vectors  = 0;
   int   miscmp   = 0;
   exp_t sbq[$];

   int_reg_scoreboard #(
      .XLEN        (32),
      .NUM_REGS    (32),
      .MAX_PENDING (4),
      .TIMEOUT_CYC (TCYC)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_flush       (flush),
      .i_issue_valid (issue_valid),
      .i_issue_rd    (issue_rd),
      .o_issue_ready (issue_ready),
      .i_cmpl_valid  (cmpl_valid),
      .i_cmpl_rd     (cmpl_rd),
      .i_rs1         (rs1),
      .i_rs2         (rs2),
      .i_rd          (rd),
      .i_rd_writes   (rd_writes),
      .o_stall       (stall),
      .o_pending_cnt (pending_cnt),
      .o_busy_vec    (busy_vec),
      .o_spurious    (spurious),
      .o_timeout     (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [31:0] pick(input int kind);
      case (kind)
         K_STALL: pick = {31'd0, stall};
         K_READY: pick = {31'd0, issue_ready};
         K_CNT:   pick = {29'd0, pending_cnt};
         K_BUSY:  pick = busy_vec;
         K_SPUR:  pick = {31'd0, spurious};
         default: pick = {31'd0, timeout};
      endcase
   endfunction

   // Monitor: compare every expectation due in this cycle
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] act;
         e   = sbq.pop_front();
         act = pick(e.kind);
         vectors = vectors + 1;
         if (e.cyc != cyc || act !== e.val) begin
            miscmp = miscmp + 1;
            $display("FAIL %s: got %h expected %h (cyc %0d, due %0d)",
                     e.name, act, e.val, cyc, e.cyc);
         end
      end
   end

   task automatic chk(input int kind, input logic [31:0] v, input string n);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.val  = v;
      e.name = n;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush       = 1'b0;
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      cmpl_valid  = 1'b0;
      cmpl_rd     = 5'd0;
      rs1         = 5'd0;
      rs2         = 5'd0;
      rd          = 5'd0;
      rd_writes   = 1'b0;
   endtask

   task automatic issue(input logic [4:0] r);
      issue_valid = 1'b1;
      issue_rd    = r;
   endtask

   task automatic cmpl(input logic [4:0] r);
      cmpl_valid = 1'b1;
      cmpl_rd    = r;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      step();
      chk(K_CNT,   32'd0, "rst_cnt");
      chk(K_BUSY,  32'd0, "rst_busy");
      chk(K_READY, 32'd1, "rst_ready");
      chk(K_STALL, 32'd0, "rst_stall");
      chk(K_SPUR,  32'd0, "rst_spur");
      chk(K_TOUT,  32'd0, "rst_tout");
      step();
      rst_n = 1'b1;

      // RAW on x5, then same-cycle completion bypass
      issue(5'd5);
      step();
      idle(); rs1 = 5'd5;
      chk(K_STALL, 32'd1,        "raw_stall");
      chk(K_BUSY,  32'h00000020, "raw_busy");
      chk(K_CNT,   32'd1,        "raw_cnt");
      step();
      cmpl(5'd5);
      chk(K_STALL, 32'd0, "raw_bypass_stall");
      chk(K_READY, 32'd1, "raw_bypass_ready");
      step();
      idle(); rs1 = 5'd5;
      chk(K_BUSY,  32'd0, "raw_cleared_busy");
      chk(K_CNT,   32'd0, "raw_cleared_cnt");
      chk(K_STALL, 32'd0, "raw_cleared_stall");
      chk(K_SPUR,  32'd0, "raw_no_spur");

      // WAW on x7, then completion + re-issue of x7 in one cycle
      idle(); issue(5'd7);
      step();
      idle(); rd = 5'd7; rd_writes = 1'b1;
      chk(K_STALL, 32'd1,        "waw_stall");
      chk(K_BUSY,  32'h00000080, "waw_busy");
      step();
      cmpl(5'd7); issue(5'd7);
      chk(K_STALL, 32'd0, "waw_bypass_stall");
      step();
      idle();
      chk(K_BUSY, 32'h00000080, "waw_reissue_busy");
      chk(K_CNT,  32'd1,        "waw_reissue_cnt");
      chk(K_SPUR, 32'd0,        "waw_no_spur");
      cmpl(5'd7);
      step();
      idle();
      chk(K_BUSY, 32'd0, "waw_done_busy");

      // rs2 path and rd without rd_writes
      issue(5'd12);
      step();
      idle(); rs2 = 5'd12;
      chk(K_STALL, 32'd1, "rs2_stall");
      step();
      idle(); rd = 5'd12;
      chk(K_STALL, 32'd0, "rd_nowrite_stall");
      cmpl(5'd12);
      step();
      idle();
      chk(K_CNT, 32'd0, "rs2_done_cnt");

      // Capacity limit and same-cycle slot reuse
      issue(5'd1); step();
      issue(5'd2); step();
      issue(5'd3); step();
      issue(5'd4); step();
      idle();
      chk(K_CNT,   32'd4,        "cap_cnt");
      chk(K_READY, 32'd0,        "cap_ready");
      chk(K_BUSY,  32'h0000001E, "cap_busy");
      step();
      cmpl(5'd2); issue(5'd9);
      chk(K_READY, 32'd1, "cap_free_ready");
      step();
      idle(); issue(5'd11);
      chk(K_CNT,   32'd4,        "cap_swap_cnt");
      chk(K_BUSY,  32'h0000021A, "cap_swap_busy");
      chk(K_READY, 32'd0,        "cap_full_ready");
      step();
      idle();
      chk(K_BUSY, 32'h0000021A, "cap_drop_busy");
      chk(K_CNT,  32'd4,        "cap_drop_cnt");
      flush = 1'b1;
      step();
      idle();
      chk(K_CNT, 32'd0, "cap_flush_cnt");

      // Flush beats same-cycle issue; completion afterwards is spurious
      issue(5'd3); step();
      issue(5'd8); step();
      idle();
      chk(K_BUSY, 32'h00000108, "fl_busy");
      chk(K_CNT,  32'd2,        "fl_cnt");
      flush = 1'b1; issue(5'd10);
      step();
      idle();
      chk(K_BUSY, 32'd0, "fl_busy_clr");
      chk(K_CNT,  32'd0, "fl_cnt_clr");
      chk(K_SPUR, 32'd0, "fl_no_spur");
      cmpl(5'd3);
      step();
      idle();
      chk(K_SPUR, 32'd1, "spur_pulse");
      chk(K_CNT,  32'd0, "spur_cnt");
      step();
      chk(K_SPUR, 32'd0, "spur_end");

      // x0: completion is spurious, issue is ignored
      cmpl(5'd0);
      step();
      idle(); issue(5'd0);
      chk(K_SPUR, 32'd1, "x0_spur");
      step();
      idle();
      chk(K_CNT,  32'd0, "x0_issue_cnt");
      chk(K_BUSY, 32'd0, "x0_issue_busy");
      chk(K_SPUR, 32'd0, "x0_spur_end");

      // Watchdog: x4 left busy
      issue(5'd4);
      step();
      idle();
      for (int i = 1; i <= TCYC; i++) begin
         step();
`ifdef SCOREBOARD_TIMEOUT_EN
         chk(K_TOUT, (i == TCYC) ? 32'd1 : 32'd0, "tout_age");
`else
         chk(K_TOUT, 32'd0, "tout_off");
`endif
      end
      flush = 1'b1;
      step();
      idle();
      step();
`ifdef SCOREBOARD_TIMEOUT_EN
      chk(K_TOUT, 32'd1, "tout_sticky");
`else
      chk(K_TOUT, 32'd0, "tout_off_flush");
`endif
      chk(K_BUSY, 32'd0, "tout_flush_busy");

      // Asynchronous reset in the middle of traffic
      issue(5'd6);
      step();
      issue(5'd13); rs1 = 5'd6; rd = 5'd6; rd_writes = 1'b1;
      rst_n = 1'b0;
      #1;
      chk(K_BUSY,  32'd0, "arst_busy");
      chk(K_CNT,   32'd0, "arst_cnt");
      chk(K_READY, 32'd1, "arst_ready");
      chk(K_STALL, 32'd0, "arst_stall");
      chk(K_TOUT,  32'd0, "arst_tout");
      step();
      idle();
      rst_n = 1'b1;
      step();
      step();

      if (sbq.size() != 0) begin
         miscmp = miscmp + 1;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end

endmodule
`default_nettype wire
